l2k_ram_arb: RTL and testbench

//  Round-robin arbiter directly downstream of the per-core l2k_msched instances.

---
 rtl/l2k_ram_arb.sv | 204 ++++++++++++++++++++
 tb/tb_l2k_ram_arb.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/l2k_ram_arb.sv
// l2k_ram_arb
//   Round-robin arbiter that merges NUM_CORES scheduler RAM ports onto one
//   external RAM bus. Only one transaction is in flight at a time. A watchdog
//   completes a hung RAM cycle with an error after TIMEOUT_CYCLES BUSY cycles
//   (TIMEOUT_CYCLES = 0 disables it). Every output is registered.
//
// Ports
//   clk          in   clock, all state on the rising edge
//   rst          in   asynchronous active-low reset
//   cli_addr     in   client i address at [32*i +: 32]
//   cli_wdata    in   client i write data at [32*i +: 32]
//   cli_we       in   client i write enable (1 = write)
//   cli_ce       in   client i request, held until its cli_rdy
//   cli_rdata    out  shared read data, valid with any cli_rdy bit
//   cli_rdy      out  one-cycle completion pulse to the granted client
//   cli_err      out  with cli_rdy: transaction ended by the watchdog
//   grant        out  one-hot current owner, 0 when idle
//   ram_addr     out  RAM address
//   ram_data_out out  RAM write data
//   ram_data_in  in   RAM read data, sampled when ram_rdy = 1
//   ram_rdy      in   RAM completion, only looked at while a command is active
//   ram_we       out  RAM write enable
//   ram_ce       out  RAM command active
module l2k_ram_arb #(
  parameter int NUM_CORES      = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CORES*32-1:0]  cli_addr,
  input  logic [NUM_CORES*32-1:0]  cli_wdata,
  input  logic [NUM_CORES-1:0]     cli_we,
  input  logic [NUM_CORES-1:0]     cli_ce,
  output logic [31:0]              cli_rdata,
  output logic [NUM_CORES-1:0]     cli_rdy,
  output logic                     cli_err,
  output logic [NUM_CORES-1:0]     grant,
  output logic [31:0]              ram_addr,
  output logic [31:0]              ram_data_out,
  input  logic [31:0]              ram_data_in,
  input  logic                     ram_rdy,
  output logic                     ram_we,
  output logic                     ram_ce
);

  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int WD_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // Watchdog value seen on the last BUSY cycle allowed before the timeout fires.
  localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT_CYCLES > 0) ? WD_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [WD_W-1:0] WD_MAX  = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                state_r;
  state_t                state_s;
  logic [PTR_W-1:0]      ptr_r;
  logic [PTR_W-1:0]      ptr_s;
  logic [WD_W-1:0]       wdog_r;
  logic [WD_W-1:0]       wdog_s;

  logic                  req_found_s;
  logic [PTR_W-1:0]      win_idx_s;
  logic [PTR_W-1:0]      scan_idx_s;
  logic [PTR_W-1:0]      next_ptr_s;
  logic [NUM_CORES-1:0]  win_onehot_s;
  logic                  wd_hit_s;

  logic [31:0]           cli_rdata_s;
  logic [NUM_CORES-1:0]  cli_rdy_s;
  logic                  cli_err_s;
  logic [NUM_CORES-1:0]  grant_s;
  logic [31:0]           ram_addr_s;
  logic [31:0]           ram_data_out_s;
  logic                  ram_we_s;
  logic                  ram_ce_s;

  // Round-robin pick: first requester scanning ptr, ptr+1, ... modulo NUM_CORES.
  always_comb begin
    req_found_s = 1'b0;
    win_idx_s   = '0;
    scan_idx_s  = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      scan_idx_s  = PTR_W'((int'(ptr_r) + k) % NUM_CORES);
      win_idx_s   = (cli_ce[scan_idx_s] && !req_found_s) ? scan_idx_s : win_idx_s;
      req_found_s = req_found_s | cli_ce[scan_idx_s];
    end
  end

  // Winner decode, pointer advance past the winner, and watchdog expiry.
  always_comb begin
    win_onehot_s = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      win_onehot_s[i] = (PTR_W'(i) == win_idx_s);
    end
    next_ptr_s = PTR_W'((int'(win_idx_s) + 1) % NUM_CORES);
    wd_hit_s   = (TIMEOUT_CYCLES > 0) && (wdog_r == WD_LAST);
  end

  // Next-state and next-output logic; every register holds unless told otherwise.
  always_comb begin
    state_s        = state_r;
    ptr_s          = ptr_r;
    wdog_s         = wdog_r;
    cli_rdata_s    = cli_rdata;
    cli_rdy_s      = cli_rdy;
    cli_err_s      = cli_err;
    grant_s        = grant;
    ram_addr_s     = ram_addr;
    ram_data_out_s = ram_data_out;
    ram_we_s       = ram_we;
    ram_ce_s       = ram_ce;
    case (state_r)
      ST_IDLE: begin
        if (req_found_s) begin
          ram_addr_s     = cli_addr[{win_idx_s, 5'd0} +: 32];
          ram_data_out_s = cli_wdata[{win_idx_s, 5'd0} +: 32];
          ram_we_s       = cli_we[win_idx_s];
          ram_ce_s       = 1'b1;
          grant_s        = win_onehot_s;
          ptr_s          = next_ptr_s;
          wdog_s         = '0;
          state_s        = ST_BUSY;
        end else begin
          grant_s   = '0;
          cli_rdy_s = '0;
          cli_err_s = 1'b0;
          ram_we_s  = 1'b0;
          ram_ce_s  = 1'b0;
          state_s   = ST_IDLE;
        end
      end
      ST_BUSY: begin
        // Saturating count: a disabled or very long watchdog must never wrap.
        wdog_s = (wdog_r == WD_MAX) ? wdog_r : wdog_r + WD_W'(1);
        // ram_rdy wins over a watchdog expiry in the same cycle.
        if (ram_rdy) begin
          cli_rdata_s = ram_data_in;
          cli_rdy_s   = grant;
          cli_err_s   = 1'b0;
          ram_ce_s    = 1'b0;
          ram_we_s    = 1'b0;
          state_s     = ST_DONE;
        end else if (wd_hit_s) begin
          cli_rdata_s = 32'hFFFF_FFFF;
          cli_rdy_s   = grant;
          cli_err_s   = 1'b1;
          ram_ce_s    = 1'b0;
          ram_we_s    = 1'b0;
          state_s     = ST_DONE;
        end else begin
          state_s = ST_BUSY;
        end
      end
      ST_DONE: begin
        cli_rdy_s = '0;
        cli_err_s = 1'b0;
        grant_s   = '0;
        state_s   = ST_IDLE;
      end
      default: begin
        cli_rdy_s = '0;
        cli_err_s = 1'b0;
        grant_s   = '0;
        ram_ce_s  = 1'b0;
        ram_we_s  = 1'b0;
        state_s   = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset clears everything, including ram_ce mid-cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      ptr_r        <= '0;
      wdog_r       <= '0;
      cli_rdata    <= 32'h0000_0000;
      cli_rdy      <= '0;
      cli_err      <= 1'b0;
      grant        <= '0;
      ram_addr     <= 32'h0000_0000;
      ram_data_out <= 32'h0000_0000;
      ram_we       <= 1'b0;
      ram_ce       <= 1'b0;
    end else begin
      state_r      <= state_s;
      ptr_r        <= ptr_s;
      wdog_r       <= wdog_s;
      cli_rdata    <= cli_rdata_s;
      cli_rdy      <= cli_rdy_s;
      cli_err      <= cli_err_s;
      grant        <= grant_s;
      ram_addr     <= ram_addr_s;
      ram_data_out <= ram_data_out_s;
      ram_we       <= ram_we_s;
      ram_ce       <= ram_ce_s;
    end
  end

endmodule

// File: tb/tb_l2k_ram_arb.sv
// Testbench for l2k_ram_arb: directed scenarios followed by randomized
// transactions, all checked against a transaction-level round-robin model.
module tb_l2k_ram_arb;

  localparam int N  = 4;
  localparam int TO = 8;

  logic            clk;
  logic            rst;
  logic [N*32-1:0] cli_addr;
  logic [N*32-1:0] cli_wdata;
  logic [N-1:0]    cli_we;
  logic [N-1:0]    cli_ce;
  logic [31:0]     cli_rdata;
  logic [N-1:0]    cli_rdy;
  logic            cli_err;
  logic [N-1:0]    grant;
  logic [31:0]     ram_addr;
  logic [31:0]     ram_data_out;
  logic [31:0]     ram_data_in;
  logic            ram_rdy;
  logic            ram_we;
  logic            ram_ce;

  int n_checks;
  int n_errors;
  int model_ptr;

  l2k_ram_arb #(.NUM_CORES(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .cli_addr(cli_addr), .cli_wdata(cli_wdata), .cli_we(cli_we), .cli_ce(cli_ce),
    .cli_rdata(cli_rdata), .cli_rdy(cli_rdy), .cli_err(cli_err), .grant(grant),
    .ram_addr(ram_addr), .ram_data_out(ram_data_out), .ram_data_in(ram_data_in),
    .ram_rdy(ram_rdy), .ram_we(ram_we), .ram_ce(ram_ce)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Reference arbitration: first requester at or after ptr, wrapping.
  function automatic int rr_pick(input logic [N-1:0] req, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (req[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic set_cli(input int i, input logic [31:0] a, input logic [31:0] wd, input logic we);
    cli_addr[32*i +: 32]  = a;
    cli_wdata[32*i +: 32] = wd;
    cli_we[i]             = we;
  endtask

  // The cycle after DONE: everything back to idle.
  task automatic idle_gap();
    @(negedge clk);
    check_val("idle_out", {grant, cli_rdy, cli_err, ram_ce, ram_we}, '0);
  endtask

  // One transaction, started at a negedge with the DUT idle. lat = negedges
  // after ram_ce is seen before ram_rdy is raised; drop_at = BUSY cycle index
  // at which the winner drops its request (-1 = never).
  task automatic do_txn(input int lat, input int drop_at, input logic [31:0] d);
    int          w;
    int          waited;
    int          n_busy;
    int          exp_busy;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_we;
    logic        exp_err;
    logic [31:0] exp_data;
    w = rr_pick(cli_ce, model_ptr);
    if (w < 0) return;
    e_addr  = cli_addr[32*w +: 32];
    e_wdata = cli_wdata[32*w +: 32];
    e_we    = cli_we[w];
    waited  = 0;
    while (ram_ce !== 1'b1 && waited < 6) begin
      @(negedge clk);
      waited++;
    end
    check_val("ce_latency", waited, 1);
    if (ram_ce !== 1'b1) return;
    check_val("grant", grant, 4'b0001 << w);
    check_val("ram_cmd", {ram_we, ram_addr, ram_data_out}, {e_we, e_addr, e_wdata});
    model_ptr = (w + 1) % N;
    exp_err   = (lat >= TO);
    exp_busy  = exp_err ? TO : lat + 1;
    exp_data  = exp_err ? 32'hFFFF_FFFF : d;
    for (n_busy = 1; n_busy <= 20; n_busy++) begin
      if (n_busy - 1 == drop_at) cli_ce[w] = 1'b0;
      if (n_busy - 1 == lat) begin
        ram_rdy     = 1'b1;
        ram_data_in = d;
      end
      @(negedge clk);
      ram_rdy     = 1'b0;
      ram_data_in = $urandom;
      if (cli_rdy !== '0) break;
      check_val("busy_hold", {ram_ce, ram_we, ram_addr, ram_data_out}, {1'b1, e_we, e_addr, e_wdata});
    end
    check_val("busy_cycles", n_busy, exp_busy);
    check_val("rdy", cli_rdy, 4'b0001 << w);
    check_val("err", cli_err, exp_err);
    check_val("rdata", cli_rdata, exp_data);
    check_val("done_bus", {ram_ce, ram_we, grant}, {2'b00, 4'b0001 << w});
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    model_ptr   = 0;
    rst         = 1'b0;
    cli_addr    = '0;
    cli_wdata   = '0;
    cli_we      = '0;
    cli_ce      = '0;
    ram_data_in = 32'h0;
    ram_rdy     = 1'b0;
    repeat (3) @(negedge clk);
    check_val("reset_ctl", {grant, cli_rdy, cli_err, ram_ce, ram_we}, '0);
    check_val("reset_data", {cli_rdata, ram_addr, ram_data_out}, '0);
    rst = 1'b1;
    idle_gap();

    // Reset in the middle of a BUSY cycle.
    set_cli(2, 32'h0000_0400, 32'h0000_0001, 1'b0);
    cli_ce = 4'b0100;
    @(negedge clk);
    check_val("pre_reset_ce", ram_ce, 1'b1);
    #2 rst = 1'b0;
    #1 check_val("async_reset", {ram_ce, cli_rdy, grant}, '0);
    cli_ce = '0;
    @(negedge clk);
    rst       = 1'b1;
    model_ptr = 0;
    idle_gap();

    // Single read from client 1.
    set_cli(1, 32'h0000_1000, 32'h0, 1'b0);
    cli_ce = 4'b0010;
    do_txn(2, -1, 32'hCAFE_BABE);
    cli_ce = '0;
    idle_gap();

    // All clients requesting continuously: grants rotate.
    for (int i = 0; i < N; i++) set_cli(i, 32'h100 * i, 32'h11 * i, i[0]);
    cli_ce = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      do_txn(0, -1, $urandom);
      idle_gap();
    end
    cli_ce = '0;
    @(negedge clk);

    // Write from client 3.
    set_cli(3, 32'h0000_0020, 32'h0000_55AA, 1'b1);
    cli_ce = 4'b1000;
    do_txn(3, -1, $urandom);
    cli_ce = '0;
    idle_gap();

    // Watchdog expiry, then ram_rdy on the very last allowed cycle.
    set_cli(0, 32'h0000_0ABC, 32'h0, 1'b0);
    cli_ce = 4'b0001;
    do_txn(100, -1, $urandom);
    idle_gap();
    do_txn(TO - 1, -1, 32'h1234_5678);
    cli_ce = '0;
    idle_gap();

    // Client 0 abandons its request while BUSY.
    set_cli(0, 32'h0000_0777, 32'h0, 1'b0);
    cli_ce = 4'b0001;
    do_txn(3, 1, 32'hDEAD_BEEF);
    cli_ce = '0;
    idle_gap();

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      int lat;
      int drop;
      for (int i = 0; i < N; i++) set_cli(i, $urandom, $urandom, 1'($urandom_range(1, 0)));
      cli_ce = 4'($urandom_range(15, 0));
      if (cli_ce == 4'b0000) cli_ce = 4'b0001 << $urandom_range(3, 0);
      lat  = ($urandom_range(9, 0) == 0) ? $urandom_range(10, 7) : $urandom_range(3, 0);
      drop = ($urandom_range(3, 0) == 0) ? $urandom_range(2, 0) : -1;
      do_txn(lat, drop, $urandom);
      cli_ce = '0;
      idle_gap();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
